mac_4: RTL

Sequential multiply-accumulate controller built around the existing 4-bit unsigned multiplier `mult_4`. It sits directly downstream of the multiplier: it accepts a run of `len` operand pairs over a valid/ready handshake, registers each 8-bit product, and sums the products into a wide accumulator. When the last product has been added it pulses `done`. Typical use is a dot product of two 4-bit vectors.

---
 rtl/mac_pkg.sv | 5 +
 rtl/mult_4.sv | 8 +
 rtl/mac_4.sv | 107 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate controller.
package mac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mac_state_t;
  localparam int PROD_W = 8;
endpackage

// File: rtl/mult_4.sv
// Combinational 4x4 unsigned multiplier; zero latency, no flow control.
module mult_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product
);
  assign product = {4'b0000, a} * {4'b0000, b};
endmodule

// File: rtl/mac_4.sv
// Accumulates len products a*b into acc, pulsing done once the last product lands.
// One pair per cycle; in_ready depends on registers only and drops once len pairs are taken.
module mac_4
  import mac_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  mac_state_t        r_state;
  logic [CNT_W-1:0]  r_rem;
  logic [PROD_W-1:0] r_p_reg;
  logic              r_p_vld;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic              r_busy;
  logic              r_done;

  logic [PROD_W-1:0] w_prod;
  logic              w_accept;
  logic [ACC_W:0]    w_sum;

  mult_4 u_mult (
    .a       (a),
    .b       (b),
    .product (w_prod)
  );

  assign in_ready = (r_state == RUN) && (r_rem != '0);
  assign w_accept = in_valid && in_ready;
  // Extra top bit of the sum is the carry-out feeding the sticky overflow flag.
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, r_p_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_p_reg <= '0;
      r_p_vld <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_p_vld <= w_accept;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_p_reg <= w_prod;
        r_rem   <= r_rem - CNT_W'(1);
      end
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (start) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_rem   <= len;
            r_p_vld <= 1'b0;
            if (len != '0) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (r_p_vld) begin
            r_acc <= w_sum[ACC_W-1:0];
            if (w_sum[ACC_W]) r_ovf <= 1'b1;
            // rem already zero means the product being added is the last one.
            if (r_rem == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign acc  = r_acc;
  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule
